// File: rtl/text_cursor_writer_if.sv
// ---------------------------------------------------------------------------
// text_cursor_writer_if
// Valid/ready stream of text operations feeding text_cursor_writer.
//   in_valid  operation valid (upstream holds it until accepted)
//   in_ready  writer can accept an operation this cycle
//   in_op     0=PUT, 1=NEWLINE, 2=CLEAR, 3=GOTO
//   in_char   glyph code for PUT (0 = blank)
//   in_x/in_y target cell for GOTO
// master = operation source, slave = text_cursor_writer.
// ---------------------------------------------------------------------------
interface text_cursor_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [4:0] in_char;
    logic [5:0] in_x;
    logic [5:0] in_y;

    modport master (
        output in_valid, in_op, in_char, in_x, in_y,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_char, in_x, in_y,
        output in_ready
    );
endinterface

// File: rtl/text_cursor_writer.sv
// ---------------------------------------------------------------------------
// text_cursor_writer
// Host-side writer for a COLS x ROWS character frame buffer. Consumes a
// stream of text operations (PUT / NEWLINE / CLEAR / GOTO), keeps a cursor
// with line wrap (no scroll) and sweeps every cell with blanks on CLEAR.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   op_if         operation stream (slave side)
//   x_o, y_o      frame write column / row        (registered)
//   char_o        frame write glyph               (registered)
//   we_o          frame write strobe, one per cell (registered)
//   cursor_x_o/y  current cursor position
//   busy_o        clear sweep in progress
// ---------------------------------------------------------------------------
module text_cursor_writer #(
    parameter int COLS           = 40,
    parameter int ROWS           = 30,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    text_cursor_writer_if.slave  op_if,
    output logic [5:0]           x_o,
    output logic [5:0]           y_o,
    output logic [4:0]           char_o,
    output logic                 we_o,
    output logic [5:0]           cursor_x_o,
    output logic [5:0]           cursor_y_o,
    output logic                 busy_o
);

    typedef enum logic [0:0] {IDLE, CLEAR} state_e;

    localparam logic [1:0] OP_PUT     = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;
    localparam logic [1:0] OP_GOTO    = 2'd3;

    localparam logic [5:0] X_MAX  = 6'(COLS - 1);
    localparam logic [5:0] Y_MAX  = 6'(ROWS - 1);
    localparam logic [5:0] X_LIM  = 6'(COLS);
    localparam logic [5:0] Y_LIM  = 6'(ROWS);

    state_e     state_q;
    logic [5:0] x_q, y_q;       // frame address; doubles as the sweep counter
    logic [4:0] chr_q;
    logic       we_q;
    logic [5:0] cx_q, cy_q;     // cursor

    logic       ready;
    logic       accept;
    logic [5:0] put_x_d, put_y_d;   // cursor after a PUT
    logic [5:0] nl_y_d;             // row after a NEWLINE / line wrap
    logic       goto_ok;

    assign ready  = (state_q == IDLE) && !reset;
    assign accept = op_if.in_valid && ready;
    assign op_if.in_ready = ready;

    always_comb begin
        nl_y_d  = (cy_q == Y_MAX) ? 6'd0 : cy_q + 6'd1;
        put_x_d = (cx_q == X_MAX) ? 6'd0 : cx_q + 6'd1;
        put_y_d = (cx_q == X_MAX) ? nl_y_d : cy_q;
        goto_ok = (op_if.in_x < X_LIM) && (op_if.in_y < Y_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
            chr_q   <= 5'd0;
            we_q    <= 1'b0;
            cx_q    <= 6'd0;
            cy_q    <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q <= 1'b0;
                    if (accept) begin
                        case (op_if.in_op)
                            OP_PUT: begin
                                we_q  <= 1'b1;
                                x_q   <= cx_q;
                                y_q   <= cy_q;
                                chr_q <= op_if.in_char;
                                cx_q  <= put_x_d;
                                cy_q  <= put_y_d;
                            end
                            OP_NEWLINE: begin
                                cx_q <= 6'd0;
                                cy_q <= nl_y_d;
                            end
                            OP_CLEAR: begin
                                // first sweep cell is emitted straight away
                                state_q <= CLEAR;
                                we_q    <= 1'b1;
                                x_q     <= 6'd0;
                                y_q     <= 6'd0;
                                chr_q   <= 5'd0;
                                cx_q    <= 6'd0;
                                cy_q    <= 6'd0;
                            end
                            OP_GOTO: begin
                                if (goto_ok) begin
                                    cx_q <= op_if.in_x;
                                    cy_q <= op_if.in_y;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    chr_q <= 5'd0;
                    if (!we_q) begin
                        // entered from reset: nothing written yet, start at (0,0)
                        we_q <= 1'b1;
                        x_q  <= 6'd0;
                        y_q  <= 6'd0;
                    end else if (x_q == X_MAX) begin
                        x_q <= 6'd0;
                        if (y_q == Y_MAX) begin
                            y_q     <= 6'd0;
                            we_q    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            y_q <= y_q + 6'd1;
                        end
                    end else begin
                        x_q <= x_q + 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_o        = x_q;
    assign y_o        = y_q;
    assign char_o     = chr_q;
    assign we_o       = we_q;
    assign cursor_x_o = cx_q;
    assign cursor_y_o = cy_q;
    assign busy_o     = (state_q == CLEAR);

endmodule

// File: tb/tb_text_cursor_writer.sv
module tb_text_cursor_writer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic r1, r0;
    text_cursor_writer_if b1();
    text_cursor_writer_if b0();

    logic [5:0] x1, y1, cx1, cy1, x0, y0, cx0, cy0;
    logic [4:0] c1, c0;
    logic       we1, we0, busy1, busy0;

    text_cursor_writer #(.COLS(40), .ROWS(30), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .reset(r1), .op_if(b1),
        .x_o(x1), .y_o(y1), .char_o(c1), .we_o(we1),
        .cursor_x_o(cx1), .cursor_y_o(cy1), .busy_o(busy1)
    );

    text_cursor_writer #(.COLS(40), .ROWS(30), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .reset(r0), .op_if(b0),
        .x_o(x0), .y_o(y0), .char_o(c0), .we_o(we0),
        .cursor_x_o(cx0), .cursor_y_o(cy0), .busy_o(busy0)
    );

    int checks = 0;
    int failures = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] ch,
                        input logic [5:0] xx, input logic [5:0] yy);
        b1.in_valid = 1'b1;
        b1.in_op    = op;
        b1.in_char  = ch;
        b1.in_x     = xx;
        b1.in_y     = yy;
        step;
        b1.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        r1 = 1'b1; r0 = 1'b1;
        step; step;
        checks++;
        if ({we1, x1, y1, c1, cx1, cy1} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs we=%b x=%0d y=%0d char=%0d cur=(%0d,%0d) want all 0",
                     we1, x1, y1, c1, cx1, cy1);
        end
        checks++;
        if (b1.in_ready !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_cor1 ready=%b busy=%b want 0,1", b1.in_ready, busy1);
        end
        r1 = 1'b0; r0 = 1'b0;
        #1;
        checks++;
        if (b0.in_ready !== 1'b1 || busy0 !== 1'b0 || we0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_cor0 ready=%b busy=%b we=%b want 1,0,0", b0.in_ready, busy0, we0);
        end
        checks++;
        if (b1.in_ready !== 1'b0 || busy1 !== 1'b1 || we1 !== 1'b0) begin
            failures++;
            $display("FAIL release_cor1 ready=%b busy=%b we=%b want 0,1,0", b1.in_ready, busy1, we1);
        end
    endtask

    task automatic test_clear_on_reset;
        step;
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd0 || y1 !== 6'd0 || c1 !== 5'd0) begin
            failures++;
            $display("FAIL sweep_first we=%b (%0d,%0d,%0d) want 1 (0,0,0)", we1, x1, y1, c1);
        end
        for (int i = 1; i < 1200; i++) begin
            step;
            checks++;
            if (we1 !== 1'b1 || busy1 !== 1'b1 || b1.in_ready !== 1'b0 || c1 !== 5'd0) begin
                failures++;
                $display("FAIL sweep_cycle%0d we=%b busy=%b ready=%b char=%0d want 1,1,0,0",
                         i, we1, busy1, b1.in_ready, c1);
            end
            if (i == 39 || i == 40 || i == 1199) begin
                checks++;
                if (x1 !== 6'(i % 40) || y1 !== 6'(i / 40)) begin
                    failures++;
                    $display("FAIL sweep_addr%0d got (%0d,%0d) want (%0d,%0d)",
                             i, x1, y1, i % 40, i / 40);
                end
            end
        end
        step;
        checks++;
        if (b1.in_ready !== 1'b1 || busy1 !== 1'b0 || we1 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_done ready=%b busy=%b we=%b want 1,0,0", b1.in_ready, busy1, we1);
        end
    endtask

    task automatic test_put;
        send(2'd0, 5'd1, 6'd0, 6'd0);
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd0 || y1 !== 6'd0 || c1 !== 5'd1) begin
            failures++;
            $display("FAIL put1 we=%b (%0d,%0d,%0d) want 1 (0,0,1)", we1, x1, y1, c1);
        end
        send(2'd0, 5'd2, 6'd0, 6'd0);
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd1 || y1 !== 6'd0 || c1 !== 5'd2) begin
            failures++;
            $display("FAIL put2 we=%b (%0d,%0d,%0d) want 1 (1,0,2)", we1, x1, y1, c1);
        end
        send(2'd0, 5'd3, 6'd0, 6'd0);
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd2 || y1 !== 6'd0 || c1 !== 5'd3) begin
            failures++;
            $display("FAIL put3 we=%b (%0d,%0d,%0d) want 1 (2,0,3)", we1, x1, y1, c1);
        end
        step;
        checks++;
        if (we1 !== 1'b0 || cx1 !== 6'd3 || cy1 !== 6'd0) begin
            failures++;
            $display("FAIL put_end we=%b cur=(%0d,%0d) want 0 (3,0)", we1, cx1, cy1);
        end
    endtask

    task automatic test_goto_wrap;
        send(2'd3, 5'd0, 6'd39, 6'd29);
        checks++;
        if (we1 !== 1'b0 || cx1 !== 6'd39 || cy1 !== 6'd29) begin
            failures++;
            $display("FAIL goto_corner we=%b cur=(%0d,%0d) want 0 (39,29)", we1, cx1, cy1);
        end
        send(2'd0, 5'd7, 6'd0, 6'd0);
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd39 || y1 !== 6'd29 || c1 !== 5'd7 || cx1 !== 6'd0 || cy1 !== 6'd0) begin
            failures++;
            $display("FAIL put_wrap we=%b (%0d,%0d,%0d) cur=(%0d,%0d) want 1 (39,29,7) (0,0)",
                     we1, x1, y1, c1, cx1, cy1);
        end
        send(2'd3, 5'd0, 6'd40, 6'd5);
        checks++;
        if (we1 !== 1'b0 || cx1 !== 6'd0 || cy1 !== 6'd0) begin
            failures++;
            $display("FAIL goto_oob we=%b cur=(%0d,%0d) want 0 (0,0)", we1, cx1, cy1);
        end
    endtask

    task automatic test_newline;
        send(2'd3, 5'd0, 6'd12, 6'd4);
        send(2'd1, 5'd0, 6'd0, 6'd0);
        checks++;
        if (we1 !== 1'b0 || cx1 !== 6'd0 || cy1 !== 6'd5) begin
            failures++;
            $display("FAIL newline we=%b cur=(%0d,%0d) want 0 (0,5)", we1, cx1, cy1);
        end
        send(2'd0, 5'd9, 6'd0, 6'd0);
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd0 || y1 !== 6'd5 || c1 !== 5'd9) begin
            failures++;
            $display("FAIL put_after_nl we=%b (%0d,%0d,%0d) want 1 (0,5,9)", we1, x1, y1, c1);
        end
        send(2'd3, 5'd0, 6'd0, 6'd29);
        send(2'd1, 5'd0, 6'd0, 6'd0);
        checks++;
        if (cx1 !== 6'd0 || cy1 !== 6'd0) begin
            failures++;
            $display("FAIL newline_wrap cur=(%0d,%0d) want (0,0)", cx1, cy1);
        end
    endtask

    task automatic test_hold_during_clear;
        int n;
        int guard;
        b1.in_valid = 1'b1;
        b1.in_op    = 2'd2;
        step;
        b1.in_op    = 2'd0;
        b1.in_char  = 5'd5;
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd0 || y1 !== 6'd0 || busy1 !== 1'b1 || b1.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_start we=%b (%0d,%0d) busy=%b ready=%b want 1 (0,0) 1 0",
                     we1, x1, y1, busy1, b1.in_ready);
        end
        n = 1;
        guard = 0;
        while (b1.in_ready !== 1'b1 && guard < 1300) begin
            step;
            guard++;
            if (we1 === 1'b1) n++;
            checks++;
            if (cx1 !== 6'd0 || cy1 !== 6'd0 || (we1 === 1'b1 && c1 !== 5'd0)) begin
                failures++;
                $display("FAIL hold_cycle%0d cur=(%0d,%0d) char=%0d want (0,0) 0", guard, cx1, cy1, c1);
            end
        end
        checks++;
        if (n != 1200 || guard >= 1300 || we1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_count writes=%0d cycles=%0d we=%b want 1200 writes, we 0", n, guard, we1);
        end
        step;
        b1.in_valid = 1'b0;
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd0 || y1 !== 6'd0 || c1 !== 5'd5 || cx1 !== 6'd1) begin
            failures++;
            $display("FAIL held_put we=%b (%0d,%0d,%0d) curx=%0d want 1 (0,0,5) 1", we1, x1, y1, c1, cx1);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int guard;
        b1.in_valid = 1'b1; b1.in_op = 2'd2;
        b0.in_valid = 1'b1; b0.in_op = 2'd2;
        step;
        b1.in_valid = 1'b0;
        b0.in_valid = 1'b0;
        for (int i = 1; i < 500; i++) step;
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd19 || y1 !== 6'd12 || we0 !== 1'b1 || x0 !== 6'd19 || y0 !== 6'd12) begin
            failures++;
            $display("FAIL cell500 d1 %b(%0d,%0d) d0 %b(%0d,%0d) want 1(19,12)", we1, x1, y1, we0, x0, y0);
        end
        r1 = 1'b1; r0 = 1'b1;
        step;
        checks++;
        if (we1 !== 1'b0 || we0 !== 1'b0 || {cx1, cy1, cx0, cy0} !== 24'd0) begin
            failures++;
            $display("FAIL abort we1=%b we0=%b cur1=(%0d,%0d) cur0=(%0d,%0d) want 0 0 (0,0)",
                     we1, we0, cx1, cy1, cx0, cy0);
        end
        r1 = 1'b0; r0 = 1'b0;
        #1;
        checks++;
        if (b0.in_ready !== 1'b1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL abort_cor0 ready=%b busy=%b want 1,0", b0.in_ready, busy0);
        end
        step;
        checks++;
        if (we1 !== 1'b1 || x1 !== 6'd0 || y1 !== 6'd0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL restart_cor1 we=%b (%0d,%0d) busy=%b want 1 (0,0) 1", we1, x1, y1, busy1);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (we0 !== 1'b0 || b0.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_cor0_%0d we=%b ready=%b want 0,1", i, we0, b0.in_ready);
            end
            step;
        end
        guard = 0;
        while (b1.in_ready !== 1'b1 && guard < 1300) begin
            step;
            guard++;
        end
        checks++;
        if (guard >= 1300 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL restart_done cycles=%0d busy=%b want finish, busy 0", guard, busy1);
        end
    endtask

    initial begin
        r1 = 1'b1; r0 = 1'b1;
        b1.in_valid = 1'b0; b1.in_op = 2'd0; b1.in_char = 5'd0; b1.in_x = 6'd0; b1.in_y = 6'd0;
        b0.in_valid = 1'b0; b0.in_op = 2'd0; b0.in_char = 5'd0; b0.in_x = 6'd0; b0.in_y = 6'd0;
        test_reset;
        test_clear_on_reset;
        test_put;
        test_goto_wrap;
        test_newline;
        test_hold_during_clear;
        test_reset_mid_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
